// File: rtl/craps_roll_ctrl.sv
// -----------------------------------------------------------------------------
// craps_roll_ctrl
//   Roll sequencer and game-rule controller for the Craps dice datapath.
//   While the roll button is held, it steps the external 6-bit LFSR. A roll
//   always gets at least MIN_SPIN steps. After the spin it draws two dice from
//   the LFSR state by rejection sampling, then applies the come-out and point
//   rules.
//
// Ports
//   clock        in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   rb           in   roll button (level, synchronised, debounced)
//   lfsr_q[5:0]  in   current LFSR state
//   lfsr_step    out  advance LFSR this cycle (to the LFSR's rb)
//   lfsr_reload  out  reload LFSR seed this cycle (to the LFSR's rst)
//   die1[2:0]    out  first die (lfsr_q[2:0]), 1..6
//   die2[2:0]    out  second die (lfsr_q[5:3]), 1..6
//   sum[3:0]     out  die1 + die2, 2..12
//   point[3:0]   out  established point, 0 during the come-out phase
//   roll_done    out  one-cycle pulse while the dice registers hold a new roll
//   win, lose    out  game result, held until the next game starts
//   busy         out  roll in progress (SPIN, SAMPLE or EVAL)
// -----------------------------------------------------------------------------
module craps_roll_ctrl #(
   parameter int unsigned MIN_SPIN = 4
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       rb,
   input  logic [5:0] lfsr_q,
   output logic       lfsr_step,
   output logic       lfsr_reload,
   output logic [2:0] die1,
   output logic [2:0] die2,
   output logic [3:0] sum,
   output logic [3:0] point,
   output logic       roll_done,
   output logic       win,
   output logic       lose,
   output logic       busy
);

   localparam logic [3:0] MIN_SPIN_C = 4'(MIN_SPIN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SPIN,
      S_SAMPLE,
      S_EVAL,
      S_OVER
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] spin_cnt_q, spin_cnt_d;
   logic [2:0] die1_q, die1_d;
   logic [2:0] die2_q, die2_d;
   logic [3:0] sum_q, sum_d;
   logic [3:0] point_q, point_d;
   logic       win_q, win_d;
   logic       lose_q, lose_d;

   logic       spin_exit;
   logic [2:0] raw1, raw2;
   logic       reject;

   assign raw1   = lfsr_q[2:0];
   assign raw2   = lfsr_q[5:3];
   // 0 and 7 cannot be die faces; redraw by stepping the LFSR once more.
   assign reject = (raw1 == 3'b000) || (raw1 == 3'b111) ||
                   (raw2 == 3'b000) || (raw2 == 3'b111);

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         spin_cnt_q <= '0;
         die1_q     <= '0;
         die2_q     <= '0;
         sum_q      <= '0;
         point_q    <= '0;
         win_q      <= 1'b0;
         lose_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         spin_cnt_q <= spin_cnt_d;
         die1_q     <= die1_d;
         die2_q     <= die2_d;
         sum_q      <= sum_d;
         point_q    <= point_d;
         win_q      <= win_d;
         lose_q     <= lose_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      spin_cnt_d  = spin_cnt_q;
      die1_d      = die1_q;
      die2_d      = die2_q;
      sum_d       = sum_q;
      point_d     = point_q;
      win_d       = win_q;
      lose_d      = lose_q;
      lfsr_step   = 1'b0;
      lfsr_reload = 1'b0;
      spin_exit   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rb) begin
               state_d    = S_SPIN;
               spin_cnt_d = '0;
            end
         end

         S_SPIN: begin
            // The counter saturates at MIN_SPIN. It only enforces the minimum
            // spin; a held button keeps stepping for as long as it is held.
            spin_exit = !rb && (spin_cnt_q >= MIN_SPIN_C);
            lfsr_step = !spin_exit;
            if (spin_cnt_q < MIN_SPIN_C)
               spin_cnt_d = spin_cnt_q + 4'd1;
            if (spin_exit)
               state_d = S_SAMPLE;
         end

         S_SAMPLE: begin
            if (lfsr_q == 6'd0) begin
               // An all-zero LFSR never advances, so reseed it instead.
               lfsr_reload = 1'b1;
            end else if (reject) begin
               lfsr_step = 1'b1;
            end else begin
               die1_d  = raw1;
               die2_d  = raw2;
               sum_d   = {1'b0, raw1} + {1'b0, raw2};
               state_d = S_EVAL;
            end
         end

         S_EVAL: begin
            if (point_q == 4'd0) begin
               if (sum_q == 4'd7 || sum_q == 4'd11) begin
                  win_d   = 1'b1;
                  state_d = S_OVER;
               end else if (sum_q == 4'd2 || sum_q == 4'd3 || sum_q == 4'd12) begin
                  lose_d  = 1'b1;
                  state_d = S_OVER;
               end else begin
                  point_d = sum_q;
                  state_d = S_IDLE;
               end
            end else if (sum_q == point_q) begin
               win_d   = 1'b1;
               state_d = S_OVER;
            end else if (sum_q == 4'd7) begin
               lose_d  = 1'b1;
               state_d = S_OVER;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_OVER: begin
            // A new game starts here, and its first roll is a come-out roll.
            // The dice keep their last values until a new roll is accepted.
            if (rb) begin
               win_d      = 1'b0;
               lose_d     = 1'b0;
               point_d    = '0;
               spin_cnt_d = '0;
               state_d    = S_SPIN;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign die1      = die1_q;
   assign die2      = die2_q;
   assign sum       = sum_q;
   assign point     = point_q;
   assign win       = win_q;
   assign lose      = lose_q;
   assign roll_done = (state_q == S_EVAL);
   assign busy      = (state_q == S_SPIN) || (state_q == S_SAMPLE) || (state_q == S_EVAL);

endmodule

// File: tb/tb_craps_roll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_craps_roll_ctrl
//   Directed bench for craps_roll_ctrl. Each roll is described by how long the
//   button is held and by the LFSR values shown during sampling. From that
//   description, the bench builds the expected cycle-by-cycle behaviour. The
//   game rules are modelled on plain integers. One compare process checks the
//   DUT against the expected values on every driven cycle.
// -----------------------------------------------------------------------------
module tb_craps_roll_ctrl;

   localparam int MIN_SPIN = 4;

   logic       clock = 1'b0;
   logic       rst   = 1'b1;
   logic       rb    = 1'b0;
   logic [5:0] lfsr_q = 6'd0;
   logic       lfsr_step, lfsr_reload, roll_done, win, lose, busy;
   logic [2:0] die1, die2;
   logic [3:0] sum, point;

   craps_roll_ctrl #(.MIN_SPIN(MIN_SPIN)) dut (
      .clock(clock), .rst(rst), .rb(rb), .lfsr_q(lfsr_q),
      .lfsr_step(lfsr_step), .lfsr_reload(lfsr_reload),
      .die1(die1), .die2(die2), .sum(sum), .point(point),
      .roll_done(roll_done), .win(win), .lose(lose), .busy(busy)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Expected values for the current cycle.
   logic exp_valid = 1'b0;
   logic exp_step, exp_reload, exp_busy, exp_done;
   // Game model.
   int m_d1 = 0, m_d2 = 0, m_sum = 0, m_point = 0;
   int m_win = 0, m_lose = 0;
   // Per-roll activity counters, filled in by the compare process.
   int step_cnt = 0, reload_cnt = 0, done_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: checks the outputs midway between the drive edge and
   // the next rising edge.
   initial begin
      forever begin
         @(negedge clock);
         #2;
         if (exp_valid) begin
            chk("lfsr_step",   int'(lfsr_step),   int'(exp_step));
            chk("lfsr_reload", int'(lfsr_reload), int'(exp_reload));
            chk("busy",        int'(busy),        int'(exp_busy));
            chk("roll_done",   int'(roll_done),   int'(exp_done));
            chk("die1",  int'(die1),  m_d1);
            chk("die2",  int'(die2),  m_d2);
            chk("sum",   int'(sum),   m_sum);
            chk("point", int'(point), m_point);
            chk("win",   int'(win),   m_win);
            chk("lose",  int'(lose),  m_lose);
            if (lfsr_step)   step_cnt++;
            if (lfsr_reload) reload_cnt++;
            if (roll_done)   done_cnt++;
         end
      end
   end

   task automatic drive(input logic rb_v, input logic [5:0] lq,
                        input logic e_step, input logic e_reload,
                        input logic e_busy, input logic e_done);
      @(negedge clock);
      rb         = rb_v;
      lfsr_q     = lq;
      exp_step   = e_step;
      exp_reload = e_reload;
      exp_busy   = e_busy;
      exp_done   = e_done;
      exp_valid  = 1'b1;
   endtask

   function automatic bit bad_face(input logic [2:0] f);
      return (f == 3'd0) || (f == 3'd7);
   endfunction

   // One roll. The button is high in the start cycle and then for `hold` SPIN
   // cycles. The sample values s0..s(n-1) are presented one per SAMPLE cycle,
   // and the last one must be acceptable.
   task automatic roll(input int hold, input int n,
                       input logic [5:0] s0, input logic [5:0] s1, input logic [5:0] s2);
      logic [5:0] s [3];
      logic [5:0] acc;
      bit game_over;
      int spins;
      s[0] = s0; s[1] = s1; s[2] = s2;
      game_over = (m_win != 0) || (m_lose != 0);
      spins = (hold > MIN_SPIN) ? hold : MIN_SPIN;
      step_cnt = 0; reload_cnt = 0; done_cnt = 0;
      drive(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);         // IDLE/OVER, button pressed
      for (int k = 0; k < spins; k++) begin
         drive(k < hold, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0);
         if (k == 0 && game_over) begin
            m_win = 0; m_lose = 0; m_point = 0;
         end
      end
      drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);         // spin ends, no step
      acc = s[n-1];
      for (int i = 0; i < n; i++) begin
         if (s[i] == 6'd0)
            drive(1'b0, s[i], 1'b0, 1'b1, 1'b1, 1'b0);
         else if (bad_face(s[i][2:0]) || bad_face(s[i][5:3]))
            drive(1'b0, s[i], 1'b1, 1'b0, 1'b1, 1'b0);
         else
            drive(1'b0, s[i], 1'b0, 1'b0, 1'b1, 1'b0);
      end
      drive(1'b0, acc, 1'b0, 1'b0, 1'b1, 1'b1);          // EVAL
      m_d1  = int'(acc[2:0]);
      m_d2  = int'(acc[5:3]);
      m_sum = m_d1 + m_d2;
      drive(1'b0, acc, 1'b0, 1'b0, 1'b0, 1'b0);          // result visible
      if (m_point == 0) begin
         if (m_sum == 7 || m_sum == 11)                  m_win = 1;
         else if (m_sum == 2 || m_sum == 3 || m_sum == 12) m_lose = 1;
         else                                            m_point = m_sum;
      end else if (m_sum == m_point) m_win = 1;
      else if (m_sum == 7)           m_lose = 1;
      #3;
   endtask

   initial begin
      // Reset state.
      #2;
      chk("rst_busy", int'(busy), 0);
      chk("rst_step", int'(lfsr_step), 0);
      chk("rst_reload", int'(lfsr_reload), 0);
      chk("rst_outs", int'({die1, die2, sum, point, roll_done, win, lose}), 0);
      #5 rst = 1'b0;

      // Come-out win after a one-cycle tap.
      roll(0, 1, 6'b011_100, 6'd0, 6'd0);
      chk("co_steps", step_cnt, 4);
      chk("co_done",  done_cnt, 1);
      chk("co_die1",  int'(die1), 4);
      chk("co_die2",  int'(die2), 3);
      chk("co_sum",   int'(sum), 7);
      chk("co_win",   int'(win), 1);
      chk("co_point", int'(point), 0);

      // Rejection: die2 = 7, then die1... die2 = 0, then snake eyes.
      roll(0, 3, 6'b111_010, 6'b000_101, 6'b001_001);
      chk("rej_steps", step_cnt, 6);
      chk("rej_sum",   int'(sum), 2);
      chk("rej_lose",  int'(lose), 1);

      // Point established, then made.
      roll(0, 1, 6'b010_011, 6'd0, 6'd0);
      chk("pt_point", int'(point), 5);
      chk("pt_nores", int'(win) + int'(lose), 0);
      roll(2, 1, 6'b001_100, 6'd0, 6'd0);
      chk("pt_win",   int'(win), 1);
      // Fresh point of 5, then a seven out.
      roll(0, 1, 6'b010_011, 6'd0, 6'd0);
      roll(0, 1, 6'b011_100, 6'd0, 6'd0);
      chk("seven_out", int'(lose), 1);

      // Lock-up recovery.
      roll(0, 2, 6'd0, 6'b010_001, 6'd0);
      chk("lk_reload", reload_cnt, 1);
      chk("lk_sum",    int'(sum), 3);
      chk("lk_lose",   int'(lose), 1);

      // Held button: 10 SPIN cycles with the button high.
      roll(10, 1, 6'b011_100, 6'd0, 6'd0);
      chk("held_steps", step_cnt, 10);

      // Set a point of 6, then reset asynchronously in the middle of SPIN.
      roll(0, 1, 6'b100_010, 6'd0, 6'd0);
      chk("pre_point", int'(point), 6);
      drive(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      #3;
      exp_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("arst_busy",  int'(busy), 0);
      chk("arst_step",  int'(lfsr_step), 0);
      chk("arst_point", int'(point), 0);
      chk("arst_dice",  int'({die1, die2, sum}), 0);
      m_d1 = 0; m_d2 = 0; m_sum = 0; m_point = 0; m_win = 0; m_lose = 0;
      @(posedge clock);
      #2 rst = 1'b0;                                 // rb stays high through release
      roll(0, 1, 6'b101_110, 6'd0, 6'd0);
      chk("post_rst_win", int'(win), 1);
      chk("post_rst_sum", int'(sum), 11);

      exp_valid = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
